// File: rtl/twiddle_seq_gen_if.sv
// ---------------------------------------------------------------------------
// twiddle_seq_gen_if
//
// Bundles the request and output-stream signals of the twiddle sequencer.
//
//   start      requester -> sequencer  one-cycle request to play out a stage
//   stage      requester -> sequencer  FFT stage, sampled with start
//   inverse    requester -> sequencer  1 = conjugate twiddles, sampled with start
//   busy       sequencer -> requester  a request is pending or being played out
//   out_valid  sequencer -> requester  data_real/data_imag hold a sample
//   out_ready  requester -> sequencer  sample accepted when out_valid && out_ready
//   data_real  sequencer -> requester  Re(W), signed Q1.(DATA_WIDTH-1)
//   data_imag  sequencer -> requester  Im(W), signed Q1.(DATA_WIDTH-1)
//   out_last   sequencer -> requester  marks the final sample of the stage
//   done       sequencer -> requester  one-cycle pulse after the last sample
//   err        sequencer -> requester  one-cycle pulse for an illegal stage
//
// The master modport is the requester/consumer side; the slave modport is
// the sequencer itself.
// ---------------------------------------------------------------------------
interface twiddle_seq_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGE_W    = 3
) ();

  logic                  start;
  logic [STAGE_W-1:0]    stage;
  logic                  inverse;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_real;
  logic [DATA_WIDTH-1:0] data_imag;
  logic                  out_last;
  logic                  done;
  logic                  err;

  modport master (
    output start,
    output stage,
    output inverse,
    output out_ready,
    input  busy,
    input  out_valid,
    input  data_real,
    input  data_imag,
    input  out_last,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  stage,
    input  inverse,
    input  out_ready,
    output busy,
    output out_valid,
    output data_real,
    output data_imag,
    output out_last,
    output done,
    output err
  );

endinterface

// File: rtl/twiddle_seq_gen.sv
// ---------------------------------------------------------------------------
// twiddle_seq_gen
//
// Twiddle-factor sequencer for a radix-2 DIT FFT of size N = 2**LOG2_NFFT.
// Only a quarter-wave cosine table C[0..N/4] is held; every W_N^k for
// k = 0..N/2-1 is rebuilt from it by octant symmetry. On request it plays
// out the N/2 per-butterfly twiddles of one stage over a valid/ready stream,
// optionally conjugated for the inverse transform.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    twiddle_seq_gen_if.slave: start/stage/inverse request,
//          busy/done/err status, out_valid/out_ready/data_real/data_imag/
//          out_last output stream
//
// Parameters:
//   LOG2_NFFT   log2 of the FFT size (>= 3)
//   DATA_WIDTH  twiddle sample width, signed Q1.(DATA_WIDTH-1)
//   STAGE_W     width of the stage field (2**STAGE_W >= LOG2_NFFT)
//   ROM_FILE    name of the reference cosine table; the table below is
//               generated at elaboration to the same contents
//               (C[j] = round(cos(2*pi*j/N) * (2**(DATA_WIDTH-1)-1)))
// ---------------------------------------------------------------------------
module twiddle_seq_gen #(
  parameter int    LOG2_NFFT  = 5,
  parameter int    DATA_WIDTH = 16,
  parameter int    STAGE_W    = 3,
  parameter string ROM_FILE   = "W_cos_q32.txt"
) (
  input logic              clk,
  input logic              rst_n,
  twiddle_seq_gen_if.slave bus
);

  localparam int NFFT = 1 << LOG2_NFFT;
  localparam int QTR  = NFFT / 4;
  // Butterfly counter and twiddle index both span 0..N/2-1.
  localparam int BW   = LOG2_NFFT - 1;

  localparam logic [BW-1:0]      B_ONE       = BW'(1);
  localparam logic [BW-1:0]      B_LAST      = BW'(NFFT / 2 - 1);
  localparam logic [BW-1:0]      Q_IDX       = BW'(QTR);
  localparam logic [STAGE_W-1:0] SHIFT_TOP   = STAGE_W'(LOG2_NFFT - 1);
  // One extra bit so that LOG2_NFFT == 2**STAGE_W still compares correctly.
  localparam logic [STAGE_W:0]   STAGE_LIMIT = (STAGE_W + 1)'(LOG2_NFFT);

  localparam real FULL_SCALE = (2.0 ** (DATA_WIDTH - 1)) - 1.0;
  localparam real TWO_PI     = 6.283185307179586;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Quarter-wave cosine table, evaluated at elaboration time with a Taylor
  // series (x <= pi/2, so 12 terms are far below one LSB of error). Values
  // are rounded to nearest; +1.0 maps to the largest positive code, so the
  // table never holds -1.0 and negation can never overflow.
  // -------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] cos_entry(input int j);
    real x;
    real term;
    real sum;
    real scaled;
    int  ival;
    x    = TWO_PI * real'(j) / real'(NFFT);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scaled = sum * FULL_SCALE;
    // cos(pi/2) can come out a hair below zero; clamp so it rounds to 0.
    if (scaled < 0.0) begin
      scaled = 0.0;
    end
    ival = $rtoi(scaled + 0.5);
    return ival[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] cos_rom [0:QTR];

  for (genvar j = 0; j <= QTR; j++) begin : g_rom
    assign cos_rom[j] = cos_entry(j);
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                state;
  state_t                state_next;

  logic                  req_valid;
  logic [STAGE_W-1:0]    req_stage;
  logic                  req_inverse;
  logic                  req_legal;

  logic [STAGE_W-1:0]    stage_q;
  logic                  inverse_q;
  logic [BW-1:0]         b;

  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] real_q;
  logic [DATA_WIDTH-1:0] imag_q;
  logic                  done_q;
  logic                  err_q;

  logic                  busy_int;
  logic                  accept;

  logic                  launch;
  logic                  reject;
  logic                  load_sample;
  logic                  step;
  logic                  finish;

  logic [BW-1:0]         b_sel;
  logic [BW-1:0]         stage_mask;
  logic [STAGE_W-1:0]    shift;
  logic [BW-1:0]         k;
  logic [BW-1:0]         m;
  logic                  upper;
  logic [BW-1:0]         re_idx;
  logic [BW-1:0]         im_idx;
  logic [DATA_WIDTH-1:0] re_mag;
  logic [DATA_WIDTH-1:0] im_mag;
  logic [DATA_WIDTH-1:0] sym_real;
  logic [DATA_WIDTH-1:0] sym_imag;

  assign req_legal = ({1'b0, req_stage} < STAGE_LIMIT);

  // A legal request waiting to launch already counts as busy, so a second
  // start in that window is ignored just like one arriving mid-run.
  assign busy_int  = (state != IDLE) || (req_valid && req_legal);
  assign accept    = out_valid_q && bus.out_ready;

  // -------------------------------------------------------------------------
  // Request register: start and its qualifiers are captured first and
  // decoded one cycle later, which gives the two-edge start-to-valid latency.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid   <= 1'b0;
      req_stage   <= '0;
      req_inverse <= 1'b0;
    end else begin
      req_valid <= bus.start && !busy_int;
      if (bus.start && !busy_int) begin
        req_stage   <= bus.stage;
        req_inverse <= bus.inverse;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    reject      = 1'b0;
    load_sample = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            launch     = 1'b1;
            state_next = LOAD;
          end else begin
            reject     = 1'b1;
          end
        end
      end
      LOAD: begin
        load_sample = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if (accept) begin
          if (out_last_q) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            step       = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Index generation and octant symmetry. LOAD produces the sample for the
  // current b (always 0); in RUN the next sample b+1 is prepared so it can
  // replace the accepted one on the same edge without a bubble.
  // -------------------------------------------------------------------------
  always_comb begin
    b_sel      = load_sample ? b : (b + B_ONE);
    // (1 << s) - 1 wraps to all ones for the last stage, which is exactly
    // the mask needed there.
    stage_mask = (B_ONE << stage_q) - B_ONE;
    shift      = SHIFT_TOP - stage_q;
    k          = (b_sel & stage_mask) << shift;
    // k < N/2, so its top bit alone tells the two octant pairs apart and
    // clearing it yields m = k - N/4.
    upper      = k[BW-1];
    m          = k & ~Q_IDX;
    if (!upper) begin
      re_idx = k;
      im_idx = Q_IDX - k;
    end else begin
      re_idx = Q_IDX - m;
      im_idx = m;
    end
    re_mag   = cos_rom[re_idx];
    im_mag   = cos_rom[im_idx];
    sym_real = upper ? ('0 - re_mag) : re_mag;
    // Forward twiddles carry -sin; conjugation simply drops that negation.
    sym_imag = inverse_q ? im_mag : ('0 - im_mag);
  end

  // -------------------------------------------------------------------------
  // Run parameters, butterfly counter and registered output stage. Without
  // an acceptance nothing here changes, which keeps data, out_last and b
  // stable under backpressure.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      inverse_q   <= 1'b0;
      b           <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      real_q      <= '0;
      imag_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= finish;
      err_q  <= reject;
      if (launch) begin
        stage_q   <= req_stage;
        inverse_q <= req_inverse;
      end
      if (load_sample || step) begin
        b           <= b_sel;
        real_q      <= sym_real;
        imag_q      <= sym_imag;
        out_valid_q <= 1'b1;
        out_last_q  <= (b_sel == B_LAST);
      end else if (finish) begin
        b           <= '0;
        real_q      <= '0;
        imag_q      <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.data_real = real_q;
  assign bus.data_imag = imag_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_twiddle_seq_gen
//
// Directed bench for twiddle_seq_gen at N = 32, 16-bit samples. Expected
// twiddles are hand-computed constants W_32^k = cos(2*pi*k/32) - j*sin(...)
// in Q1.15 with +1.0 = 0x7FFF. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_twiddle_seq_gen;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  twiddle_seq_gen_if #(.DATA_WIDTH(16), .STAGE_W(3)) bus ();

  twiddle_seq_gen #(
    .LOG2_NFFT (5),
    .DATA_WIDTH(16),
    .STAGE_W   (3),
    .ROM_FILE  ("W_cos_q32.txt")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // W_32^k for k = 0..15 (stage 4 plays k = b).
  logic [15:0] exp_re [16] = '{
    16'h7FFF, 16'h7D89, 16'h7641, 16'h6A6D, 16'h5A82, 16'h471C, 16'h30FB, 16'h18F9,
    16'h0000, 16'hE707, 16'hCF05, 16'hB8E4, 16'hA57E, 16'h9593, 16'h89BF, 16'h8277
  };
  logic [15:0] exp_im [16] = '{
    16'h0000, 16'hE707, 16'hCF05, 16'hB8E4, 16'hA57E, 16'h9593, 16'h89BF, 16'h8277,
    16'h8001, 16'h8277, 16'h89BF, 16'h9593, 16'hA57E, 16'hB8E4, 16'hCF05, 16'hE707
  };
  // Imaginary parts of the conjugated twiddles (+sin).
  logic [15:0] exp_im_inv [16] = '{
    16'h0000, 16'h18F9, 16'h30FB, 16'h471C, 16'h5A82, 16'h6A6D, 16'h7641, 16'h7D89,
    16'h7FFF, 16'h7D89, 16'h7641, 16'h6A6D, 16'h5A82, 16'h471C, 16'h30FB, 16'h18F9
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulse start for one cycle; returns at the falling edge after the
  // rising edge that sampled it.
  task automatic applyStimulus(input logic [2:0] st, input logic inv);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.stage   = st;
    bus.inverse = inv;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stage     = '0;
    bus.inverse   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_compared++;
    if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.err, bus.data_real, bus.data_imag} !== 37'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got %h expected 0",
               {bus.busy, bus.out_valid, bus.out_last, bus.done, bus.err, bus.data_real, bus.data_imag});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({bus.busy, bus.out_valid, bus.done, bus.err} !== 4'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_after_reset: got %b expected 0000",
               {bus.busy, bus.out_valid, bus.done, bus.err});
    end
  endtask

  task automatic test_stage0;
    logic [33:0] got;
    logic [33:0] want;
    applyStimulus(3'd0, 1'b0);
    n_compared++;
    if ({bus.out_valid, bus.busy} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL s0_latency_e0: valid,busy got %b expected 01", {bus.out_valid, bus.busy});
    end
    @(negedge clk);
    n_compared++;
    if ({bus.out_valid, bus.busy} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL s0_latency_e1: valid,busy got %b expected 01", {bus.out_valid, bus.busy});
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b1, 16'h7FFF, 16'h0000, (i == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL s0_sample %0d: got %h expected %h", i, got, want);
      end
      @(negedge clk);
    end
    n_compared++;
    if ({bus.done, bus.out_valid, bus.busy} !== 3'b100) begin
      n_mismatched++;
      $display("[TB] FAIL s0_done: done,valid,busy got %b expected 100", {bus.done, bus.out_valid, bus.busy});
    end
    @(negedge clk);
    n_compared++;
    if (bus.done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL s0_done_width: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_stage1;
    logic [33:0] got;
    logic [33:0] want;
    applyStimulus(3'd1, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = (i % 2 == 0) ? {1'b1, 16'h7FFF, 16'h0000, (i == 15)}
                          : {1'b1, 16'h0000, 16'h8001, (i == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL s1_sample %0d: got %h expected %h", i, got, want);
      end
      @(negedge clk);
    end
    n_compared++;
    if (bus.done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL s1_done: got %b expected 1", bus.done);
    end
  endtask

  task automatic test_stage4;
    logic [33:0] got;
    logic [33:0] want;
    applyStimulus(3'd4, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b1, exp_re[i], exp_im[i], (i == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL s4_sample %0d: got %h expected %h", i, got, want);
      end
      @(negedge clk);
    end
    n_compared++;
    if (bus.done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL s4_done: got %b expected 1", bus.done);
    end
  endtask

  task automatic test_inverse;
    logic [33:0] got;
    logic [33:0] want;
    applyStimulus(3'd4, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b1, exp_re[i], exp_im_inv[i], (i == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL inv_sample %0d: got %h expected %h", i, got, want);
      end
      // Changing the request qualifiers mid-run must not affect the stream.
      if (i == 3) begin
        bus.inverse = 1'b0;
        bus.stage   = 3'd1;
      end
      @(negedge clk);
    end
    n_compared++;
    if (bus.done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL inv_done: got %b expected 1", bus.done);
    end
  endtask

  task automatic test_backpressure;
    logic [33:0] got;
    logic [33:0] want;
    int          idx;
    int          stall;
    applyStimulus(3'd4, 1'b0);
    repeat (2) @(negedge clk);
    idx   = 0;
    stall = 0;
    // 16 samples plus three stalled cycles on sample 5.
    for (int c = 0; c < 19; c++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b1, exp_re[idx], exp_im[idx], (idx == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL bp_cycle %0d sample %0d: got %h expected %h", c, idx, got, want);
      end
      if (idx == 5 && stall < 3) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = 1'b1;
        idx++;
      end
      @(negedge clk);
    end
    n_compared++;
    if ({bus.done, bus.out_valid} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL bp_done: done,valid got %b expected 10", {bus.done, bus.out_valid});
    end
  endtask

  task automatic test_start_while_busy;
    logic [34:0] got;
    logic [34:0] want;
    applyStimulus(3'd4, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      got  = {bus.err, bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b0, 1'b1, exp_re[i], exp_im[i], (i == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL busy_sample %0d: got %h expected %h", i, got, want);
      end
      if (i == 2) begin
        bus.start   = 1'b1;
        bus.stage   = 3'd0;
        bus.inverse = 1'b1;
      end else begin
        bus.start   = 1'b0;
      end
      @(negedge clk);
    end
    n_compared++;
    if ({bus.done, bus.err} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL busy_done: done,err got %b expected 10", {bus.done, bus.err});
    end
    @(negedge clk);
    n_compared++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL busy_idle_after: busy,valid got %b expected 00", {bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_illegal_stage;
    applyStimulus(3'd5, 1'b0);
    n_compared++;
    if ({bus.err, bus.busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL err_early: err,busy got %b expected 00", {bus.err, bus.busy});
    end
    @(negedge clk);
    n_compared++;
    if ({bus.err, bus.busy, bus.out_valid} !== 3'b100) begin
      n_mismatched++;
      $display("[TB] FAIL err_pulse: err,busy,valid got %b expected 100", {bus.err, bus.busy, bus.out_valid});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if ({bus.err, bus.busy, bus.out_valid} !== 3'b000) begin
        n_mismatched++;
        $display("[TB] FAIL err_after %0d: err,busy,valid got %b expected 000", i, {bus.err, bus.busy, bus.out_valid});
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [33:0] got;
    logic [33:0] want;
    applyStimulus(3'd4, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b1, exp_re[i], exp_im[i], 1'b0};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL abort_sample %0d: got %h expected %h", i, got, want);
      end
      if (i < 7) begin
        @(negedge clk);
      end
    end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.err, bus.data_real, bus.data_imag} !== 37'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_outputs: got %h expected 0",
               {bus.busy, bus.out_valid, bus.out_last, bus.done, bus.err, bus.data_real, bus.data_imag});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({bus.done, bus.busy, bus.out_valid} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_done: done,busy,valid got %b expected 000", {bus.done, bus.busy, bus.out_valid});
    end
    applyStimulus(3'd4, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      got  = {bus.out_valid, bus.data_real, bus.data_imag, bus.out_last};
      want = {1'b1, exp_re[i], exp_im[i], (i == 15)};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL restart_sample %0d: got %h expected %h", i, got, want);
      end
      @(negedge clk);
    end
    n_compared++;
    if (bus.done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL restart_done: got %b expected 1", bus.done);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    $display("[TB] twiddle_seq_gen directed test, N=32");
    test_reset();
    test_stage0();
    test_stage1();
    test_stage4();
    test_inverse();
    test_backpressure();
    test_start_while_busy();
    test_illegal_stage();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/twiddle_seq_gen.md
Name: twiddle_seq_gen

Overview:
Parametrised twiddle-factor sequencer for the radix-2 DIT FFT datapath. It stores only a quarter-wave cosine table of N/4+1 entries and derives every W_N^k for k = 0..N/2-1 by octant symmetry. It plays out the per-butterfly twiddle sequence for a requested stage over a valid/ready stream. It also supports an inverse (conjugate) mode and backpressure.

Parameters:
LOG2_NFFT, 5, log2 of FFT size N (N = 2**LOG2_NFFT, LOG2_NFFT >= 3)
DATA_WIDTH, 16, twiddle sample width, signed Q1.(DATA_WIDTH-1)
STAGE_W, 3, width of stage input; must satisfy 2**STAGE_W >= LOG2_NFFT
ROM_FILE, "W_cos_q32.txt", $readmemb file with N/4+1 entries C[j] = cos(2*pi*j/N), with +1.0 stored as 2**(DATA_WIDTH-1)-1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to play out one stage
stage  input  STAGE_W  FFT stage s (0 = first, span 1), sampled with start
inverse  input  1  1 = conjugate twiddles (IFFT), sampled with start
busy  output  1  high from accepted start until last output accepted
out_valid  output  1  data_real/data_imag valid
out_ready  input  1  downstream accepts when out_valid && out_ready
data_real  output  DATA_WIDTH  Re(W), signed
data_imag  output  DATA_WIDTH  Im(W), signed
out_last  output  1  high with final sample of the stage (b = N/2-1)
done  output  1  one-cycle pulse in cycle after last sample accepted
err  output  1  one-cycle pulse when start is given with stage >= LOG2_NFFT

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, out_valid, out_last, done, err = 0; data_real = data_imag = 0; counter b = 0; latched stage and inverse = 0.
- States:
  - IDLE -> LOAD on start with legal stage and busy=0.
  - LOAD -> RUN (one cycle): computes sample b=0 and registers it.
  - RUN -> IDLE when the out_last sample is accepted; done pulses the following cycle.
- Start is ignored while busy; err does not pulse for ignored starts.
- An illegal stage in IDLE causes an err pulse next cycle, and the block stays IDLE.
- Latency: start sampled at edge E; out_valid = 1 after edge E+2.
- Throughput: one sample per cycle while out_ready = 1.
- Index: for butterfly b = 0..N/2-1, k = (b mod 2**s) << (LOG2_NFFT-1-s).
- Symmetry, Q = N/4:
  - k < Q: Re = C[k], Im = -C[Q-k].
  - k >= Q, m = k-Q: Re = -C[Q-m], Im = -C[m].
- Negation is two's complement. The table never holds -1.0, so no overflow.
- inverse = 1: Im output is negated after symmetry. Re is unchanged.
- Output is registered, and the table read plus symmetry form one pipeline stage.
- Backpressure: while out_valid && !out_ready, data, out_last and b hold stable. A new sample appears only on the edge after acceptance, so there is no bubble with out_ready = 1.
- out_last = 1 only on the sample with b = N/2-1.
- b wraps to 0 on return to IDLE.
- stage and inverse are latched at start, so later changes have no effect mid-run.
- Reset asserted mid-run aborts immediately to reset values, with no done pulse.

Test Plan:
1. N=32, start with stage=0, out_ready=1 -> 16 samples, all (0x7FFF, 0x0000). out_last on the 16th, done 1 cycle later, first out_valid 2 cycles after start.
2. stage=1 -> samples alternate (0x7FFF, 0x0000), (0x0000, 0x8001) for 16 samples.
3. stage=4 -> k = b. Sample 4 = (0x5A82, 0xA57E); sample 8 = (0x0000, 0x8001); sample 12 = (0xA57E, 0xA57E).
4. Same as case 3 with inverse=1 -> sample 4 = (0x5A82, 0x5A82), sample 8 = (0x0000, 0x7FFF); toggling inverse mid-run has no effect.
5. stage=4 with out_ready low for 3 cycles at sample 5 -> data and out_last stable throughout. Sequence completes in 16 + 3 cycles with no lost or duplicated samples.
6. Start during busy -> ignored. stage=5 in IDLE -> err pulse, no output. rst_n low at sample 7 -> all outputs 0 immediately, no done; a new start afterwards yields a correct full sequence.
